// File: rtl/ipm_mcu_pkg.sv
// Shared definitions for the ipm MCU-bus host: bus widths, default cycle timing,
// FSM encoding, latched command record and the word/byte lane helper.
package ipm_mcu_pkg;

  localparam int MCU_AW = 4;
  localparam int MCU_DW = 8;

  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 2;
  localparam int DEF_NBYTES     = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } mcu_state_e;

  typedef struct packed {
    logic              write;
    logic [MCU_AW-1:0] addr;
    logic [31:0]       wdata;
  } mcu_cmd_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Byte k of an nbytes-wide word, most significant byte first.
  function automatic logic [MCU_DW-1:0] word_byte(input logic [31:0] w, input logic [1:0] k,
                                                  input int nbytes);
    int sh;
    sh = (nbytes - 1 - int'(k)) * MCU_DW;
    return MCU_DW'(w >> sh);
  endfunction

endpackage

// File: rtl/ipm_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; both stages clear on reset.
module ipm_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ipm_mcu_host.sv
// Host initiator for the ipm 8-bit MCU bus: one 32-bit word command becomes NBYTES
// setup/strobe/hold byte cycles at a fixed address, MSB first.
module ipm_mcu_host
  import ipm_mcu_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int NBYTES     = DEF_NBYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [MCU_AW-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              irq,
  output logic              irq_rise,
  output logic [MCU_AW-1:0] bus_addr,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [MCU_DW-1:0] bus_data_o,
  output logic              bus_data_oe,
  input  logic [MCU_DW-1:0] bus_data_i,
  input  logic              bus_int_i
);

  localparam int             PW        = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  localparam logic [PW-1:0]  SETUP_LD  = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0]  STROBE_LD = PW'(STROBE_CYC - 1);
  localparam logic [PW-1:0]  HOLD_LD   = PW'(HOLD_CYC - 1);
  localparam logic [1:0]     LAST_BYTE = 2'(NBYTES - 1);

  mcu_state_e        state_q, state_d;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic [1:0]        byte_q, byte_d;
  mcu_cmd_t          cmd_q, cmd_d;
  logic [31:0]       rsh_q, rsh_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              bus_rd_q, bus_rd_d;
  logic              bus_wr_q, bus_wr_d;
  logic              bus_data_oe_q, bus_data_oe_d;
  logic [MCU_DW-1:0] bus_data_o_q, bus_data_o_d;
  logic              irq_s, irq_q, irq_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    cmd_d       = cmd_q;
    rsh_d       = rsh_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready_q) begin
        state_d = SETUP;
        cnt_d   = SETUP_LD;
        byte_d  = '0;
        rsh_d   = '0;
        cmd_d   = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
      end
      SETUP: if (cnt_q == '0) begin
        state_d = STROBE;
        cnt_d   = STROBE_LD;
      end else cnt_d = cnt_q - 1'b1;
      STROBE: if (cnt_q == '0) begin
        // Read data is captured on the edge that ends the strobe.
        state_d = HOLD;
        cnt_d   = HOLD_LD;
        if (!cmd_q.write) rsh_d = {rsh_q[23:0], bus_data_i};
      end else cnt_d = cnt_q - 1'b1;
      HOLD: if (cnt_q == '0) begin
        if (byte_q == LAST_BYTE) begin
          state_d     = DONE;
          rsp_rdata_d = cmd_q.write ? '0 : rsh_q;
        end else begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          byte_d  = byte_q + 1'b1;
        end
      end else cnt_d = cnt_q - 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered from the next state so strobes never glitch.
    cmd_ready_d   = (state_d == IDLE);
    rsp_valid_d   = (state_d == DONE);
    bus_wr_d      = (state_d == STROBE) && cmd_d.write;
    bus_rd_d      = (state_d == STROBE) && !cmd_d.write;
    bus_data_oe_d = cmd_d.write && (state_d inside {SETUP, STROBE, HOLD});
    bus_data_o_d  = bus_data_oe_d ? word_byte(cmd_d.wdata, byte_d, NBYTES) : '0;
    irq_d         = irq_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      byte_q        <= '0;
      cmd_q         <= '0;
      rsh_q         <= '0;
      rsp_rdata_q   <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      bus_rd_q      <= 1'b0;
      bus_wr_q      <= 1'b0;
      bus_data_oe_q <= 1'b0;
      bus_data_o_q  <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      byte_q        <= byte_d;
      cmd_q         <= cmd_d;
      rsh_q         <= rsh_d;
      rsp_rdata_q   <= rsp_rdata_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      bus_rd_q      <= bus_rd_d;
      bus_wr_q      <= bus_wr_d;
      bus_data_oe_q <= bus_data_oe_d;
      bus_data_o_q  <= bus_data_o_d;
      irq_q         <= irq_d;
    end
  end

  ipm_sync2 #(.W(1)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus_int_i),
    .q   (irq_s)
  );

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign bus_addr    = cmd_q.addr;
  assign bus_rd      = bus_rd_q;
  assign bus_wr      = bus_wr_q;
  assign bus_data_o  = bus_data_o_q;
  assign bus_data_oe = bus_data_oe_q;
  assign irq         = irq_s;
  assign irq_rise    = irq_s & ~irq_q;

endmodule

// File: tb/tb_ipm_mcu_host.sv
// Bench for ipm_mcu_host: default-timing instance plus a 1/1/1, 2-byte instance,
// driven with directed and $urandom commands against a bus-level reference model.
module tb_ipm_mcu_host;

  localparam int SU = 2, ST = 4, HO = 2, NB = 4;
  localparam int LAT    = NB * (SU + ST + HO) + 1;
  localparam int OE_CYC = NB * (SU + ST + HO);

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        irq, irq_rise;
  logic [3:0]  bus_addr;
  logic        bus_rd, bus_wr, bus_data_oe;
  logic [7:0]  bus_data_o, bus_data_i;
  logic        bus_int_i;

  logic        s_cmd_valid, s_cmd_ready, s_cmd_write;
  logic [3:0]  s_cmd_addr;
  logic [31:0] s_cmd_wdata;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_rdata;
  logic        s_irq, s_irq_rise;
  logic [3:0]  s_bus_addr;
  logic        s_bus_rd, s_bus_wr, s_bus_data_oe;
  logic [7:0]  s_bus_data_o, s_bus_data_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ipm_mcu_host dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .irq(irq), .irq_rise(irq_rise), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe), .bus_data_i(bus_data_i),
    .bus_int_i(bus_int_i)
  );

  ipm_mcu_host #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .NBYTES(2)) dut_s (
    .clk(clk), .rst(rst), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_write(s_cmd_write), .cmd_addr(s_cmd_addr), .cmd_wdata(s_cmd_wdata),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .irq(s_irq), .irq_rise(s_irq_rise),
    .bus_addr(s_bus_addr), .bus_rd(s_bus_rd), .bus_wr(s_bus_wr), .bus_data_o(s_bus_data_o),
    .bus_data_oe(s_bus_data_oe), .bus_data_i(s_bus_data_i), .bus_int_i(bus_int_i)
  );

  typedef struct {
    int          lat;
    int          nrsp;
    int          npulse;
    int          bad_width;
    int          oe_cyc;
    int          addr_bad;
    int          overlap;
    int          rdy_hi;
    logic        rdy0;
    logic [31:0] bytes;
    logic [31:0] rdata;
  } obs_t;

  // Issues one command on the default instance and records what the bus did.
  // The slave side answers read strobe n with byte n of rw (MSB first) and
  // drives junk whenever no strobe is active.
  task automatic do_xfer(input logic w, input logic [3:0] a, input logic [31:0] wd,
                         input logic [31:0] rw, output obs_t o);
    int   width;
    logic prev;
    o.lat = -1; o.nrsp = 0; o.npulse = 0; o.bad_width = 0; o.oe_cyc = 0;
    o.addr_bad = 0; o.overlap = 0; o.rdy_hi = 0; o.bytes = '0; o.rdata = '0;
    width = 0; prev = 1'b0;
    @(negedge clk);
    o.rdy0 = cmd_ready;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = $urandom;
      if (bus_rd && bus_wr) o.overlap++;
      if (bus_data_oe) o.oe_cyc++;
      if (o.lat < 0 && cmd_ready) o.rdy_hi++;
      if (o.lat < 0 && bus_addr !== a) o.addr_bad++;
      if (rsp_valid) begin
        o.nrsp++;
        if (o.lat < 0) begin o.lat = c; o.rdata = rsp_rdata; end
      end
      if ((bus_rd || bus_wr) && !prev) begin
        o.npulse++;
        width = 1;
        if (bus_wr) o.bytes = {o.bytes[23:0], bus_data_o};
        if (bus_rd && o.npulse <= NB) bus_data_i = rw[(NB - o.npulse)*8 +: 8];
      end else if (bus_rd || bus_wr) begin
        width++;
      end else begin
        if (prev && width != ST) o.bad_width++;
        bus_data_i = 8'($urandom);
      end
      prev = bus_rd || bus_wr;
      if (o.lat >= 0 && c > o.lat) break;
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({cmd_ready, rsp_valid, irq, irq_rise, bus_rd, bus_wr, bus_data_oe} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b exp 1000000",
               {cmd_ready, rsp_valid, irq, irq_rise, bus_rd, bus_wr, bus_data_oe});
    end
    vectors++;
    if ({rsp_rdata, bus_addr, bus_data_o} !== 44'h0) begin
      miscompares++;
      $display("FAIL reset_data: rdata %h addr %h data_o %h exp 0", rsp_rdata, bus_addr, bus_data_o);
    end
    vectors++;
    if ({s_cmd_ready, s_rsp_valid, s_bus_rd, s_bus_wr, s_bus_data_oe} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_small: got %b exp 10000",
               {s_cmd_ready, s_rsp_valid, s_bus_rd, s_bus_wr, s_bus_data_oe});
    end
  endtask

  task automatic test_write();
    obs_t o;
    do_xfer(1'b1, 4'd3, 32'hA1B2C3D4, 32'h0, o);
    vectors++; if (o.rdy0 !== 1'b1) begin miscompares++; $display("FAIL wr_ready0: got %b exp 1", o.rdy0); end
    vectors++; if (o.lat != LAT) begin miscompares++; $display("FAIL wr_latency: got %0d exp %0d", o.lat, LAT); end
    vectors++; if (o.bytes !== 32'hA1B2C3D4) begin miscompares++; $display("FAIL wr_bytes: got %h exp a1b2c3d4", o.bytes); end
    vectors++; if (o.npulse != NB || o.bad_width != 0) begin miscompares++; $display("FAIL wr_pulses: got %0d pulses %0d bad widths exp %0d/0", o.npulse, o.bad_width, NB); end
    vectors++; if (o.oe_cyc != OE_CYC) begin miscompares++; $display("FAIL wr_oe: got %0d exp %0d", o.oe_cyc, OE_CYC); end
    vectors++; if (o.addr_bad != 0 || o.rdy_hi != 0) begin miscompares++; $display("FAIL wr_addr_ready: addr_bad %0d ready_hi %0d exp 0/0", o.addr_bad, o.rdy_hi); end
    vectors++; if (o.nrsp != 1 || o.rdata !== 32'h0) begin miscompares++; $display("FAIL wr_rsp: got %0d pulses rdata %h exp 1/0", o.nrsp, o.rdata); end
  endtask

  task automatic test_read();
    obs_t o;
    do_xfer(1'b0, 4'd5, 32'h0, 32'h11223344, o);
    vectors++; if (o.lat != LAT) begin miscompares++; $display("FAIL rd_latency: got %0d exp %0d", o.lat, LAT); end
    vectors++; if (o.rdata !== 32'h11223344) begin miscompares++; $display("FAIL rd_data: got %h exp 11223344", o.rdata); end
    vectors++; if (o.npulse != NB || o.bad_width != 0 || o.oe_cyc != 0) begin miscompares++; $display("FAIL rd_bus: pulses %0d bad %0d oe %0d exp %0d/0/0", o.npulse, o.bad_width, o.oe_cyc, NB); end
    vectors++; if (o.bytes !== 32'h0 || o.addr_bad != 0) begin miscompares++; $display("FAIL rd_nowr_addr: wr bytes %h addr_bad %0d exp 0/0", o.bytes, o.addr_bad); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic        w;
    logic [3:0]  a;
    logic [31:0] wd, rw;
    for (int i = 0; i < 8; i++) begin
      w = 1'($urandom); a = 4'($urandom); wd = $urandom; rw = $urandom;
      do_xfer(w, a, wd, rw, o);
      vectors++; if (o.lat != LAT || o.nrsp != 1) begin miscompares++; $display("FAIL rand%0d_rsp: lat %0d n %0d exp %0d/1", i, o.lat, o.nrsp, LAT); end
      vectors++; if (o.rdata !== (w ? 32'h0 : rw)) begin miscompares++; $display("FAIL rand%0d_rdata: got %h exp %h", i, o.rdata, w ? 32'h0 : rw); end
      vectors++; if (o.bytes !== (w ? wd : 32'h0)) begin miscompares++; $display("FAIL rand%0d_wbytes: got %h exp %h", i, o.bytes, w ? wd : 32'h0); end
      vectors++; if (o.oe_cyc != (w ? OE_CYC : 0) || o.addr_bad != 0 || o.overlap != 0) begin miscompares++; $display("FAIL rand%0d_bus: oe %0d addr_bad %0d ovl %0d", i, o.oe_cyc, o.addr_bad, o.overlap); end
    end
  endtask

  task automatic test_back_to_back();
    int          ready_at, rsp1, rsp2, nwr, nrd, bad;
    logic        prev_rd, prev_wr;
    logic [31:0] rw, rd2;
    ready_at = -1; rsp1 = -1; rsp2 = -1; nwr = 0; nrd = 0; bad = 0;
    prev_rd = 1'b0; prev_wr = 1'b0; rw = $urandom; rd2 = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd7; cmd_wdata = 32'h0BADF00D;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin cmd_write = 1'b0; cmd_addr = 4'd9; end
      if (ready_at >= 0 && c == ready_at + 1) cmd_valid = 1'b0;
      if (ready_at < 0 && cmd_ready) ready_at = c;
      if ((bus_rd && (bus_wr || prev_wr)) || (bus_wr && prev_rd)) bad++;
      if (bus_wr && !prev_wr) nwr++;
      if (bus_rd && !prev_rd) begin
        if (nrd < NB) bus_data_i = rw[(NB - 1 - nrd)*8 +: 8];
        nrd++;
      end else if (!bus_rd) bus_data_i = 8'($urandom);
      prev_rd = bus_rd; prev_wr = bus_wr;
      if (rsp_valid) begin
        if (rsp1 < 0) rsp1 = c;
        else if (rsp2 < 0) begin rsp2 = c; rd2 = rsp_rdata; break; end
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    vectors++; if (ready_at != LAT + 1) begin miscompares++; $display("FAIL b2b_ready: got cycle %0d exp %0d", ready_at, LAT + 1); end
    vectors++; if (rsp1 != LAT || rsp2 != 2 * LAT + 1) begin miscompares++; $display("FAIL b2b_rsp: got %0d,%0d exp %0d,%0d", rsp1, rsp2, LAT, 2 * LAT + 1); end
    vectors++; if (nwr != NB || nrd != NB || bad != 0) begin miscompares++; $display("FAIL b2b_strobes: wr %0d rd %0d overlap %0d exp %0d/%0d/0", nwr, nrd, bad, NB, NB); end
    vectors++; if (rd2 !== rw) begin miscompares++; $display("FAIL b2b_rdata: got %h exp %h", rd2, rw); end
  endtask

  task automatic test_reset_mid();
    int   n, seen;
    logic prev, hit;
    obs_t o;
    n = 0; seen = 0; prev = 1'b0; hit = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd2; cmd_wdata = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (bus_wr && !prev) n++;
      prev = bus_wr;
      if (n == 2 && bus_wr) begin hit = 1'b1; break; end
    end
    vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL rstmid_reach: second strobe got %b exp 1", hit); end
    rst = 1'b1;
    #1;
    vectors++; if ({bus_wr, bus_data_oe, cmd_ready} !== 3'b001) begin miscompares++; $display("FAIL rstmid_drop: wr/oe/ready got %b exp 001", {bus_wr, bus_data_oe, cmd_ready}); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid || bus_wr || bus_rd) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rstmid_abandon: got %0d active cycles exp 0", seen); end
    do_xfer(1'b1, 4'd6, 32'hCAFE0123, 32'h0, o);
    vectors++; if (o.lat != LAT || o.bytes !== 32'hCAFE0123) begin miscompares++; $display("FAIL rstmid_next: lat %0d bytes %h exp %0d/cafe0123", o.lat, o.bytes, LAT); end
  endtask

  task automatic test_irq();
    int   rises;
    logic hist [0:63];
    rises = 0;
    bus_int_i = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 bus_int_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b exp 0", irq); end
    @(negedge clk);
    vectors++; if ({irq, irq_rise} !== 2'b11) begin miscompares++; $display("FAIL irq_edge: irq/rise got %b exp 11", {irq, irq_rise}); end
    repeat (6) begin
      @(negedge clk);
      if (irq_rise) rises++;
    end
    vectors++; if (rises != 0 || irq !== 1'b1) begin miscompares++; $display("FAIL irq_held: extra rises %0d irq %b exp 0/1", rises, irq); end
    for (int k = 0; k < 64; k++) begin
      if (k >= 3) begin
        vectors++;
        if ({irq, irq_rise, s_irq} !== {hist[k-2], hist[k-2] & ~hist[k-3], hist[k-2]}) begin
          miscompares++;
          $display("FAIL irq_rand%0d: irq/rise/s_irq got %b exp %b", k, {irq, irq_rise, s_irq},
                   {hist[k-2], hist[k-2] & ~hist[k-3], hist[k-2]});
        end
      end
      hist[k] = 1'($urandom);
      bus_int_i = hist[k];
      @(negedge clk);
    end
  endtask

  task automatic test_small_cfg();
    int          lat, np, badw, width;
    logic        prev;
    logic [31:0] bytes, rdata, rw, exp_r;
    for (int t = 0; t < 2; t++) begin
      lat = -1; np = 0; badw = 0; width = 0; prev = 1'b0; bytes = '0; rdata = '0;
      rw = $urandom;
      exp_r = {16'h0, rw[15:0]};
      @(negedge clk);
      s_cmd_valid = 1'b1; s_cmd_write = (t == 0); s_cmd_addr = 4'd1; s_cmd_wdata = 32'h0000BEEF;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        s_cmd_valid = 1'b0;
        if (s_rsp_valid && lat < 0) begin lat = c; rdata = s_rsp_rdata; end
        if ((s_bus_rd || s_bus_wr) && !prev) begin
          np++; width = 1;
          if (s_bus_wr) bytes = {bytes[23:0], s_bus_data_o};
          if (s_bus_rd && np <= 2) s_bus_data_i = rw[(2 - np)*8 +: 8];
        end else if (s_bus_rd || s_bus_wr) width++;
        else begin
          if (prev && width != 1) badw++;
          s_bus_data_i = 8'($urandom);
        end
        prev = s_bus_rd || s_bus_wr;
        if (lat >= 0) break;
      end
      vectors++; if (lat != 7) begin miscompares++; $display("FAIL small%0d_latency: got %0d exp 7", t, lat); end
      vectors++; if (np != 2 || badw != 0) begin miscompares++; $display("FAIL small%0d_pulses: got %0d bad %0d exp 2/0", t, np, badw); end
      if (t == 0) begin
        vectors++; if (bytes !== 32'h0000BEEF || rdata !== 32'h0) begin miscompares++; $display("FAIL small_wr: bytes %h rdata %h exp 0000beef/0", bytes, rdata); end
      end else begin
        vectors++; if (rdata !== exp_r) begin miscompares++; $display("FAIL small_rd: got %h exp %h", rdata, exp_r); end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    s_cmd_valid = 1'b0; s_cmd_write = 1'b0; s_cmd_addr = '0; s_cmd_wdata = '0;
    bus_data_i = '0; s_bus_data_i = '0; bus_int_i = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_write();
    test_read();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_irq();
    test_small_cfg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
